// File: rtl/pipe_split_chan_pkg.sv
// Shared helpers for pipe_split_chan: MSB-first channel slicing and occupancy width.
package pipe_split_chan_pkg;

  localparam int MAX_BUS_W = 1024;
  localparam int MAX_CH_W  = 256;

  function automatic int occ_w(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Channel 0 is the most-significant slice, matching {ch0, ch1, ...} concatenation order.
  function automatic logic [MAX_CH_W-1:0] ch_slice(input logic [MAX_BUS_W-1:0] bus,
                                                   input int idx,
                                                   input int num_ch,
                                                   input int ch_w);
    logic [MAX_BUS_W-1:0] v_sh;
    v_sh = bus >> ((num_ch - 1 - idx) * ch_w);
    return v_sh[MAX_CH_W-1:0] & ~({MAX_CH_W{1'b1}} << ch_w);
  endfunction

endpackage

// File: rtl/pipe_split_stage.sv
// One valid/ready register stage; advance decision is made by the parent so the
// ready chain stays a single combinational pass.
module pipe_split_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_adv,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_split_chan.sv
// STAGES-deep valid/ready pipeline that splits a packed bus into gated channel slices.
// Optional per-channel parity under `define PIPE_SPLIT_CHAN_PARITY_EN.
module pipe_split_chan
  import pipe_split_chan_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 8,
  parameter int STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef PIPE_SPLIT_CHAN_PARITY_EN
  input  logic                       inj_par_err,
  output logic [0:NUM_CH-1]          out_ch_par,
`endif
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*CH_W-1:0]     in_data,
  input  logic [0:NUM_CH-1]          in_ch_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_ch_data [NUM_CH],
  output logic [0:NUM_CH-1]          out_ch_en,
  output logic [occ_w(STAGES)-1:0]   occupancy
);

  localparam int DW = NUM_CH * CH_W;
  localparam int OW = occ_w(STAGES);
`ifdef PIPE_SPLIT_CHAN_PARITY_EN
  localparam int PW = 2 * NUM_CH + DW;
`else
  localparam int PW = NUM_CH + DW;
`endif

  // Enable bit i belongs to channel i; bit 0 is the MSB, mirroring the bus order.
  typedef logic [0:NUM_CH-1] ch_en_t;

  logic [DW-1:0]     w_gated;
  logic [DW-1:0]     w_last_data;
  logic [STAGES:0]   w_valid;
  logic [PW-1:0]     w_pay [STAGES+1];
  logic [STAGES-1:0] w_adv;
  logic              w_accept;
  logic              w_xfer;
  logic [OW-1:0]     r_occ;
`ifdef PIPE_SPLIT_CHAN_PARITY_EN
  ch_en_t            w_par_in;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CH_W-1:0] w_in_slice;
    logic [CH_W-1:0] w_gate_slice;
    assign w_in_slice   = CH_W'(ch_slice(MAX_BUS_W'(in_data), i, NUM_CH, CH_W));
    assign w_gate_slice = in_ch_en[i] ? w_in_slice : '0;
    assign w_gated[(NUM_CH-i)*CH_W-1 -: CH_W] = w_gate_slice;
`ifdef PIPE_SPLIT_CHAN_PARITY_EN
    if (i == 0) begin : g_inj
      assign w_par_in[i] = (^w_gate_slice) ^ inj_par_err;
    end else begin : g_plain
      assign w_par_in[i] = ^w_gate_slice;
    end
`endif
    assign out_ch_data[i] = CH_W'(ch_slice(MAX_BUS_W'(w_last_data), i, NUM_CH, CH_W));
  end

  assign w_valid[0] = in_valid;
`ifdef PIPE_SPLIT_CHAN_PARITY_EN
  assign w_pay[0] = {in_ch_en, w_gated, w_par_in};
  assign {out_ch_en, w_last_data, out_ch_par} = w_pay[STAGES];
`else
  assign w_pay[0] = {in_ch_en, w_gated};
  assign {out_ch_en, w_last_data} = w_pay[STAGES];
`endif

  // Stage k advances when any stage from k onward is empty or the consumer takes the beat.
  always_comb begin
    logic v_run;
    w_adv = '0;
    v_run = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      v_run    = v_run | ~w_valid[k+1];
      w_adv[k] = v_run;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_split_stage #(.W(PW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_adv   (w_adv[k]),
      .i_valid (w_valid[k]),
      .i_data  (w_pay[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_pay[k+1])
    );
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_valid[STAGES];
  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_accept && !w_xfer) begin
      r_occ <= r_occ + 1'b1;
    end else if (!w_accept && w_xfer) begin
      r_occ <= r_occ - 1'b1;
    end
  end

  assign occupancy = r_occ;

endmodule
